// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
//   Serial transmit half of the UART. Accepts a byte on a start request and
//   shifts out an asynchronous frame: start bit, 8 data bits LSB first,
//   optional parity bit, then one or two stop bits. Bit timing comes from a
//   clock-cycle divider, so the whole block runs on the system clock.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   PARITY_EN    : 1 inserts a parity bit after the data bits
//   PARITY_ODD   : 1 selects odd parity, 0 even (ignored if PARITY_EN = 0)
//   STOP_BITS    : number of stop bits, 1 or 2
//
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   UART_STA_TX : start request, level-sensitive, sampled only in IDLE
//   UART_TxREG  : byte to send, captured on the accepting edge
//   UART_TXD    : registered serial output, idles high
//   UART_BUSY   : high while a frame is in progress
//   UART_DONE   : one-cycle pulse as the last stop bit completes
// ---------------------------------------------------------------------------
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UART_STA_TX,
    input  logic [7:0] UART_TxREG,
    output logic       UART_TXD,
    output logic       UART_BUSY,
    output logic       UART_DONE
);

    // The stop phase is counted as a single span of STOP_BITS bit periods,
    // so the counter has to reach CLKS_PER_BIT * STOP_BITS - 1.
    localparam int CNT_MAX = CLKS_PER_BIT * STOP_BITS - 1;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CNT_MAX);
    localparam logic             PAR_INV   = (PARITY_ODD != 0);
    localparam logic             PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_par;
    logic             r_txd;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_par_nxt;
    logic             w_txd_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_txd   <= w_txd_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Frame payload; only ever read while busy, so it needs no reset
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
        r_par   <= w_par_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (UART_STA_TX) begin
                    w_shift_nxt = UART_TxREG;
                    w_par_nxt   = (^UART_TxREG) ^ PAR_INV;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = PAR_ON ? S_PARITY : S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == STOP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that TXD/BUSY change on
        // the same edge the state does (start bit visible on the accepting edge).
        w_busy_nxt = (w_state_nxt != S_IDLE);
        unique case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[w_idx_nxt];
            S_PARITY: w_txd_nxt = w_par_nxt;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    assign UART_TXD  = r_txd;
    assign UART_BUSY = r_busy;
    assign UART_DONE = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic       sta;
    logic [7:0] txreg;

    // 0: no parity, 1 stop   1: even parity   2: odd parity   3: 2 stop bits
    logic txd_a  [4];
    logic busy_a [4];
    logic done_a [4];

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx_core #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
        .clk(clk), .rst(rst), .UART_STA_TX(sta), .UART_TxREG(txreg),
        .UART_TXD(txd_a[0]), .UART_BUSY(busy_a[0]), .UART_DONE(done_a[0]));
    uart_tx_core #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
        .clk(clk), .rst(rst), .UART_STA_TX(sta), .UART_TxREG(txreg),
        .UART_TXD(txd_a[1]), .UART_BUSY(busy_a[1]), .UART_DONE(done_a[1]));
    uart_tx_core #(.CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_d2 (
        .clk(clk), .rst(rst), .UART_STA_TX(sta), .UART_TxREG(txreg),
        .UART_TXD(txd_a[2]), .UART_BUSY(busy_a[2]), .UART_DONE(done_a[2]));
    uart_tx_core #(.CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d3 (
        .clk(clk), .rst(rst), .UART_STA_TX(sta), .UART_TxREG(txreg),
        .UART_TXD(txd_a[3]), .UART_BUSY(busy_a[3]), .UART_DONE(done_a[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame vector: exp bit i is the i-th transmitted bit (bit 0 = start).
    typedef struct {
        int         sel;
        logic [7:0] data;
        logic [11:0] exp;
        int         nbits;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] outs(input int sel);
        return {txd_a[sel], busy_a[sel], done_a[sel]};
    endfunction

    // Compares {TXD,BUSY,DONE}
    task automatic check(input string name, input int cyc, input logic [2:0] act,
                         input logic [2:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d txd/busy/done got=%b want=%b", name, cyc, act, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sta = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        sta   = 1'b1;
        txreg = v.data;
        tick();
        sta   = 1'b0;
        txreg = ~v.data;
        for (int cyc = 0; cyc < v.nbits * C; cyc++) begin
            check($sformatf("frame%0d_%02h", v.sel, v.data), cyc, outs(v.sel),
                  {v.exp[cyc / C], 1'b1, 1'b0});
            tick();
        end
        check($sformatf("done%0d_%02h", v.sel, v.data), v.nbits * C, outs(v.sel), 3'b101);
        tick();
        check($sformatf("idle%0d_%02h", v.sel, v.data), v.nbits * C + 1, outs(v.sel), 3'b100);
    endtask

    initial begin
        logic [11:0] e1;
        logic [11:0] e2;
        logic [2:0]  want;

        vecs[0] = '{sel: 0, data: 8'hAA, exp: 12'h354, nbits: 10};
        vecs[1] = '{sel: 0, data: 8'h00, exp: 12'h200, nbits: 10};
        vecs[2] = '{sel: 0, data: 8'hFF, exp: 12'h3FE, nbits: 10};
        vecs[3] = '{sel: 0, data: 8'h01, exp: 12'h202, nbits: 10};
        vecs[4] = '{sel: 1, data: 8'h07, exp: 12'h60E, nbits: 11};
        vecs[5] = '{sel: 2, data: 8'h07, exp: 12'h40E, nbits: 11};
        vecs[6] = '{sel: 1, data: 8'h03, exp: 12'h406, nbits: 11};
        vecs[7] = '{sel: 2, data: 8'h03, exp: 12'h606, nbits: 11};
        vecs[8] = '{sel: 3, data: 8'h00, exp: 12'h600, nbits: 11};

        // Reset held with a pending request
        rst   = 1'b1;
        sta   = 1'b1;
        txreg = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_hold", i, outs(0), 3'b100);
        end
        rst = 1'b0;
        tick();
        check("start_after_reset", 0, outs(0), 3'b010);

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            do_reset();
            run_frame(vecs[i]);
        end

        // Continuous request: 0x55 then 0x3C with one idle cycle between
        do_reset();
        e1    = 12'h2AA;
        e2    = 12'h278;
        sta   = 1'b1;
        txreg = 8'h55;
        tick();
        for (int cyc = 0; cyc <= 81; cyc++) begin
            if (cyc == 10) txreg = 8'h3C;
            if (cyc < 40)       want = {e1[cyc / C], 2'b10};
            else if (cyc == 40) want = 3'b101;
            else if (cyc < 81)  want = {e2[(cyc - 41) / C], 2'b10};
            else                want = 3'b101;
            if (cyc == 81) sta = 1'b0;
            check("b2b", cyc, outs(0), want);
            tick();
        end
        check("b2b_idle", 82, outs(0), 3'b100);

        // Reset during data bit 3 (cycles 16..19)
        do_reset();
        sta   = 1'b1;
        txreg = 8'hAA;
        tick();
        sta = 1'b0;
        for (int cyc = 0; cyc < 17; cyc++) tick();
        check("pre_abort", 17, outs(0), 3'b110);
        rst = 1'b1;
        tick();
        check("abort", 18, outs(0), 3'b100);
        rst = 1'b0;
        for (int cyc = 19; cyc < 19 + 30; cyc++) begin
            tick();
            check("abort_quiet", cyc, outs(0), 3'b100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
